// File: rtl/face_det_pkg.sv
// face_det_pkg: definitions shared between the DVP capture front end and the
// face detector.
//   IMG_WIDTH_DEF / IMG_HEIGHT_DEF : default raster size
//   rgb565_t                       : one RGB565 pixel
//   cap_state_e                    : capture FSM states
//   sat_inc10                      : 10-bit increment that saturates at 1023
package face_det_pkg;

    localparam int IMG_WIDTH_DEF  = 640;
    localparam int IMG_HEIGHT_DEF = 480;

    typedef logic [15:0] rgb565_t;

    typedef enum logic [1:0] {
        WAIT_VSYNC = 2'd0,
        WAIT_FRAME = 2'd1,
        ACTIVE     = 2'd2
    } cap_state_e;

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/dvp_pixel_capture_if.sv
// dvp_pixel_capture_if: pixel stream from the camera capture to the detector.
//   pixel_out      : RGB565 pixel
//   data_valid_out : one-cycle strobe per pixel
//   sof / eol      : first pixel of frame / last pixel of line (with strobe)
//   x_pos / y_pos  : raster position of pixel_out
// master = producer (capture), slave = consumer (detector).
interface dvp_pixel_capture_if;
    import face_det_pkg::*;

    rgb565_t    pixel_out;
    logic       data_valid_out;
    logic       sof;
    logic       eol;
    logic [9:0] x_pos;
    logic [9:0] y_pos;

    modport master (output pixel_out, data_valid_out, sof, eol, x_pos, y_pos);
    modport slave  (input  pixel_out, data_valid_out, sof, eol, x_pos, y_pos);
endinterface

// File: rtl/dvp_byte_packer.sv
// dvp_byte_packer: registers the DVP pins, detects VSYNC/HREF edges and pairs
// camera bytes into RGB565 pixels.
//   cam_vsync_i/cam_href_i/cam_data_i : raw camera pins
//   active_i      : pairing allowed (capture FSM in ACTIVE)
//   vsync_o/href_o: registered VSYNC/HREF
//   vsync_rise_o/vsync_fall_o/href_fall_o : edges vs. a second delayed copy
//   phase_o       : 1 when a first byte is held waiting for its partner
//   pixel_o/pixel_stb_o : assembled pixel, valid in the cycle of the 2nd byte
module dvp_byte_packer
    import face_det_pkg::*;
#(
    parameter bit HI_BYTE_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cam_vsync_i,
    input  logic       cam_href_i,
    input  logic [7:0] cam_data_i,
    input  logic       active_i,
    output logic       vsync_o,
    output logic       href_o,
    output logic       vsync_rise_o,
    output logic       vsync_fall_o,
    output logic       href_fall_o,
    output logic       phase_o,
    output rgb565_t    pixel_o,
    output logic       pixel_stb_o
);

    logic       vs_q, hr_q, vs_qq, hr_qq;
    logic [7:0] data_q;
    logic [7:0] first_q, first_d;
    logic       phase_q, phase_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q    <= 1'b0;
            hr_q    <= 1'b0;
            vs_qq   <= 1'b0;
            hr_qq   <= 1'b0;
            data_q  <= '0;
            first_q <= '0;
            phase_q <= 1'b0;
        end else begin
            vs_q    <= cam_vsync_i;
            hr_q    <= cam_href_i;
            vs_qq   <= vs_q;
            hr_qq   <= hr_q;
            data_q  <= cam_data_i;
            first_q <= first_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        phase_d     = phase_q;
        first_d     = first_q;
        pixel_stb_o = 1'b0;
        if (!active_i || !hr_q) begin
            phase_d = 1'b0;
        end else if (!phase_q) begin
            first_d = data_q;
            phase_d = 1'b1;
        end else begin
            pixel_stb_o = 1'b1;
            phase_d     = 1'b0;
        end
    end

    assign pixel_o      = HI_BYTE_FIRST ? {first_q, data_q} : {data_q, first_q};
    assign vsync_o      = vs_q;
    assign href_o       = hr_q;
    assign vsync_rise_o = vs_q & ~vs_qq;
    assign vsync_fall_o = ~vs_q & vs_qq;
    assign href_fall_o  = ~hr_q & hr_qq;
    assign phase_o      = phase_q;

endmodule

// File: rtl/dvp_pixel_capture.sv
// dvp_pixel_capture: OV7670-style DVP capture producing an RGB565 raster
// stream with position, frame markers and sticky malformation flags.
//   clk, rst_n          : pixel clock, async active-low reset
//   enable              : capture enable, looked at only at frame boundaries
//   cam_vsync/href/data : camera pins
//   err_clr             : clears line_err/frame_err (a same-cycle set wins)
//   pix                 : pixel stream (master side)
//   frame_done          : one-cycle pulse at end of each captured frame
//   line_err/frame_err  : sticky error flags
module dvp_pixel_capture
    import face_det_pkg::*;
#(
    parameter int IMG_WIDTH     = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT    = IMG_HEIGHT_DEF,
    parameter bit HI_BYTE_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       cam_vsync,
    input  logic                       cam_href,
    input  logic [7:0]                 cam_data,
    input  logic                       err_clr,
    dvp_pixel_capture_if.master        pix,
    output logic                       frame_done,
    output logic                       line_err,
    output logic                       frame_err
);

    localparam logic [9:0] W10 = 10'(IMG_WIDTH);
    localparam logic [9:0] H10 = 10'(IMG_HEIGHT);

    logic    vs, hr, vs_rise, vs_fall, hr_fall, phase, pk_stb;
    rgb565_t pk_pixel;

    cap_state_e state_q, state_d;
    logic [9:0] col_q, col_d, line_q, line_d;
    rgb565_t    pixel_q, pixel_d;
    logic [9:0] x_q, x_d, y_q, y_d;
    logic       valid_q, valid_d, sof_q, sof_d, eol_q, eol_d;
    logic       fdone_q, fdone_d, lerr_q, lerr_d, ferr_q, ferr_d;
    logic       line_set, frame_set;

    dvp_byte_packer #(.HI_BYTE_FIRST(HI_BYTE_FIRST)) u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .cam_vsync_i  (cam_vsync),
        .cam_href_i   (cam_href),
        .cam_data_i   (cam_data),
        .active_i     (state_q == ACTIVE),
        .vsync_o      (vs),
        .href_o       (hr),
        .vsync_rise_o (vs_rise),
        .vsync_fall_o (vs_fall),
        .href_fall_o  (hr_fall),
        .phase_o      (phase),
        .pixel_o      (pk_pixel),
        .pixel_stb_o  (pk_stb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_VSYNC;
            col_q   <= '0;
            line_q  <= '0;
            pixel_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            fdone_q <= 1'b0;
            lerr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            line_q  <= line_d;
            pixel_q <= pixel_d;
            x_q     <= x_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            fdone_q <= fdone_d;
            lerr_q  <= lerr_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        line_d    = line_q;
        pixel_d   = pixel_q;
        x_d       = x_q;
        y_d       = y_q;
        sof_d     = sof_q;
        eol_d     = eol_q;
        valid_d   = 1'b0;
        fdone_d   = 1'b0;
        line_set  = 1'b0;
        frame_set = 1'b0;

        unique case (state_q)
            WAIT_VSYNC: begin
                if (enable && vs) state_d = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                col_d  = '0;
                line_d = '0;
                if (vs_fall) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (vs_rise) begin
                    fdone_d = 1'b1;
                    col_d   = '0;
                    if (line_q != H10) frame_set = 1'b1;
                    // VSYNC arriving while HREF is still high truncates the line.
                    if (hr) begin
                        line_set  = 1'b1;
                        frame_set = 1'b1;
                    end
                    state_d = enable ? WAIT_FRAME : WAIT_VSYNC;
                end else begin
                    // Strobe (needs href=1) and href fall (href=0) never coincide.
                    if (pk_stb) begin
                        if (col_q < W10 && line_q < H10) begin
                            valid_d = 1'b1;
                            pixel_d = pk_pixel;
                            x_d     = col_q;
                            y_d     = line_q;
                            sof_d   = (col_q == '0) && (line_q == '0);
                            eol_d   = (col_q == W10 - 10'd1);
                        end
                        col_d = sat_inc10(col_q);
                    end
                    if (hr_fall) begin
                        if (phase || col_q != W10) line_set = 1'b1;
                        if (line_q >= H10) frame_set = 1'b1;
                        line_d = sat_inc10(line_q);
                        col_d  = '0;
                    end
                end
            end
            default: state_d = WAIT_VSYNC;
        endcase

        lerr_d = line_set  ? 1'b1 : (err_clr ? 1'b0 : lerr_q);
        ferr_d = frame_set ? 1'b1 : (err_clr ? 1'b0 : ferr_q);
    end

    assign pix.pixel_out      = pixel_q;
    assign pix.data_valid_out = valid_q;
    assign pix.sof            = sof_q;
    assign pix.eol            = eol_q;
    assign pix.x_pos          = x_q;
    assign pix.y_pos          = y_q;
    assign frame_done         = fdone_q;
    assign line_err           = lerr_q;
    assign frame_err          = ferr_q;

endmodule

// File: tb/tb_dvp_pixel_capture.sv
// tb_dvp_pixel_capture: directed bench for dvp_pixel_capture on an 8x4 raster.
// u_dut (HI_BYTE_FIRST=1) carries the main checks; u_dut_lo (HI_BYTE_FIRST=0)
// shares the pins and is checked for byte order only.
module tb_dvp_pixel_capture;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       cam_vsync = 1'b0;
    logic       cam_href = 1'b0;
    logic [7:0] cam_data = '0;
    logic       err_clr = 1'b0;
    logic       fd, lerr, ferr, fd_lo, lerr_lo, ferr_lo;

    dvp_pixel_capture_if p0 ();
    dvp_pixel_capture_if p1 ();

    dvp_pixel_capture #(.IMG_WIDTH(8), .IMG_HEIGHT(4), .HI_BYTE_FIRST(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .cam_vsync(cam_vsync),
        .cam_href(cam_href), .cam_data(cam_data), .err_clr(err_clr), .pix(p0),
        .frame_done(fd), .line_err(lerr), .frame_err(ferr)
    );

    dvp_pixel_capture #(.IMG_WIDTH(8), .IMG_HEIGHT(4), .HI_BYTE_FIRST(1'b0)) u_dut_lo (
        .clk(clk), .rst_n(rst_n), .enable(enable), .cam_vsync(cam_vsync),
        .cam_href(cam_href), .cam_data(cam_data), .err_clr(err_clr), .pix(p1),
        .frame_done(fd_lo), .line_err(lerr_lo), .frame_err(ferr_lo)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Strobe log of the main DUT, written only by this monitor.
    logic [15:0] pix_log [0:511];
    logic [9:0]  x_log   [0:511];
    logic [9:0]  y_log   [0:511];
    logic        sof_log [0:511];
    logic        eol_log [0:511];
    int          log_n  = 0;
    int          fd_cnt = 0;

    always @(negedge clk) begin
        if (p0.data_valid_out) begin
            if (log_n < 512) begin
                pix_log[log_n] = p0.pixel_out;
                x_log[log_n]   = p0.x_pos;
                y_log[log_n]   = p0.y_pos;
                sof_log[log_n] = p0.sof;
                eol_log[log_n] = p0.eol;
            end
            log_n++;
        end
        if (fd) fd_cnt++;
    end

    // Pixel x of line y is sent as bytes x then y.
    task automatic send_line(input int nbytes, input int y, input bit clr_on_fall);
        for (int b = 0; b < nbytes; b++) begin
            @(negedge clk);
            cam_href = 1'b1;
            cam_data = (b % 2 == 0) ? 8'(b / 2) : 8'(y);
        end
        @(negedge clk);
        cam_href = 1'b0;
        cam_data = '0;
        if (clr_on_fall) begin
            @(negedge clk) err_clr = 1'b1;
            @(negedge clk) err_clr = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic start_frame();
        @(negedge clk) cam_vsync = 1'b1;
        repeat (4) @(negedge clk);
        cam_vsync = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic end_frame(input bit exp_fd);
        @(negedge clk) cam_vsync = 1'b1;
        @(negedge clk) chk("frame_done_early", fd, 1'b0);
        @(negedge clk) chk("frame_done_pulse", fd, exp_fd);
        @(negedge clk) chk("frame_done_after", fd, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_errs();
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
        @(negedge clk);
        chk("clr_line_err", lerr, 1'b0);
        chk("clr_frame_err", ferr, 1'b0);
    endtask

    task automatic chk_strobe(input int idx, input int x, input int y);
        chk("pix", pix_log[idx], 32'((x << 8) | y));
        chk("x_pos", x_log[idx], 32'(x));
        chk("y_pos", y_log[idx], 32'(y));
    endtask

    int base, fbase;

    initial begin
        // reset state
        #12;
        chk("rst_valid", p0.data_valid_out, 1'b0);
        chk("rst_pixel", p0.pixel_out, 16'h0);
        chk("rst_xy", {p0.x_pos, p0.y_pos}, 20'h0);
        chk("rst_marks", {p0.sof, p0.eol, fd, lerr, ferr}, 5'h0);
        @(negedge clk) rst_n = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clk);

        // nominal 8x4 frame
        base = log_n; fbase = fd_cnt;
        start_frame();
        for (int l = 0; l < 4; l++) send_line(16, l, 1'b0);
        end_frame(1'b1);
        chk("nom_strobes", log_n - base, 32);
        for (int i = 0; i < 32; i++) begin
            chk_strobe(base + i, i % 8, i / 8);
            chk("nom_sof", sof_log[base + i], (i == 0));
            chk("nom_eol", eol_log[base + i], (i % 8 == 7));
        end
        chk("nom_frame_done", fd_cnt - fbase, 1);
        chk("nom_line_err", lerr, 1'b0);
        chk("nom_frame_err", ferr, 1'b0);

        // byte order and two-cycle latency: bytes 34 then 12
        start_frame();
        @(negedge clk) begin cam_href = 1'b1; cam_data = 8'h34; end
        @(negedge clk) cam_data = 8'h12;
        @(negedge clk) begin cam_href = 1'b0; cam_data = '0; end
        chk("lat_not_yet", p0.data_valid_out, 1'b0);
        @(negedge clk);
        chk("lat_valid", p0.data_valid_out, 1'b1);
        chk("hi_first_pix", p0.pixel_out, 16'h3412);
        chk("lo_first_pix", p1.pixel_out, 16'h1234);
        chk("lo_first_valid", p1.data_valid_out, 1'b1);
        @(negedge clk);
        chk("strobe_one_cycle", p0.data_valid_out, 1'b0);
        repeat (3) @(negedge clk);
        end_frame(1'b1);
        clear_errs();

        // odd line (15 bytes), err_clr coincident with the line_err set
        base = log_n;
        start_frame();
        send_line(15, 0, 1'b1);
        chk("odd_set_wins", lerr, 1'b1);
        for (int l = 1; l < 4; l++) send_line(16, l, 1'b0);
        end_frame(1'b1);
        chk("odd_strobes", log_n - base, 31);
        chk_strobe(base + 6, 6, 0);
        chk_strobe(base + 7, 0, 1);
        chk("odd_line_err", lerr, 1'b1);
        chk("odd_frame_err", ferr, 1'b0);
        clear_errs();

        // long line of 10 pixels in a 4-line frame
        base = log_n;
        start_frame();
        send_line(20, 0, 1'b0);
        for (int l = 1; l < 4; l++) send_line(16, l, 1'b0);
        end_frame(1'b1);
        chk("long_strobes", log_n - base, 32);
        chk_strobe(base + 7, 7, 0);
        chk_strobe(base + 8, 0, 1);
        chk("long_line_err", lerr, 1'b1);
        chk("long_frame_err", ferr, 1'b0);
        clear_errs();

        // 5-line frame
        base = log_n;
        start_frame();
        for (int l = 0; l < 5; l++) send_line(16, l, 1'b0);
        end_frame(1'b1);
        chk("tall_strobes", log_n - base, 32);
        chk_strobe(base + 31, 7, 3);
        chk("tall_line_err", lerr, 1'b0);
        chk("tall_frame_err", ferr, 1'b1);
        clear_errs();

        // vsync rises in the middle of line 2
        base = log_n; fbase = fd_cnt;
        start_frame();
        send_line(16, 0, 1'b0);
        send_line(16, 1, 1'b0);
        for (int b = 0; b < 6; b++) begin
            @(negedge clk);
            cam_href = 1'b1;
            cam_data = (b % 2 == 0) ? 8'(b / 2) : 8'd2;
        end
        @(negedge clk) cam_vsync = 1'b1;
        @(negedge clk) begin cam_href = 1'b0; cam_data = '0; end
        repeat (4) @(negedge clk);
        chk("mid_strobes", log_n - base, 19);
        chk("mid_frame_done", fd_cnt - fbase, 1);
        chk("mid_line_err", lerr, 1'b1);
        chk("mid_frame_err", ferr, 1'b1);
        clear_errs();
        base = log_n;
        start_frame();
        for (int l = 0; l < 4; l++) send_line(16, l, 1'b0);
        end_frame(1'b1);
        chk("after_mid_strobes", log_n - base, 32);
        chk_strobe(base, 0, 0);
        chk("after_mid_errs", {lerr, ferr}, 2'b00);

        // enable dropped during frame 1
        base = log_n; fbase = fd_cnt;
        start_frame();
        send_line(16, 0, 1'b0);
        enable = 1'b0;
        for (int l = 1; l < 4; l++) send_line(16, l, 1'b0);
        end_frame(1'b1);
        chk("en_f1_strobes", log_n - base, 32);
        base = log_n;
        start_frame();
        for (int l = 0; l < 4; l++) send_line(16, l, 1'b0);
        end_frame(1'b0);
        chk("en_f2_strobes", log_n - base, 0);
        chk("en_frame_done", fd_cnt - fbase, 1);

        // reset asserted mid-line
        enable = 1'b1;
        start_frame();
        send_line(16, 0, 1'b0);
        for (int b = 0; b < 6; b++) begin
            @(negedge clk);
            cam_href = 1'b1;
            cam_data = (b % 2 == 0) ? 8'(b / 2) : 8'd1;
        end
        chk("pre_rst_pixel", p0.pixel_out, 16'h0101);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_pixel", p0.pixel_out, 16'h0);
        chk("rst_mid_x", p0.x_pos, 10'd0);
        chk("rst_mid_marks", {p0.data_valid_out, p0.sof, p0.eol}, 3'b000);
        base = log_n;
        @(negedge clk) rst_n = 1'b1;
        for (int b = 6; b < 16; b++) begin
            @(negedge clk);
            cam_data = (b % 2 == 0) ? 8'(b / 2) : 8'd1;
        end
        @(negedge clk) cam_href = 1'b0;
        repeat (3) @(negedge clk);
        send_line(16, 2, 1'b0);
        end_frame(1'b0);
        chk("rst_no_strobes", log_n - base, 0);
        start_frame();
        for (int l = 0; l < 4; l++) send_line(16, l, 1'b0);
        end_frame(1'b1);
        chk("rst_resume_strobes", log_n - base, 32);
        chk_strobe(base + 31, 7, 3);
        chk("rst_resume_errs", {lerr, ferr}, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
